dac_data_out: RTL

//  Transmit-side counterpart of the ADC capture path: streams 12-bit samples to a parallel DAC bus.

---
 rtl/dac_out_pkg.sv | 13 +
 rtl/sync_fifo.sv | 69 ++++++
 rtl/dac_data_out.sv | 130 +++++++++++++
 3 files changed

// File: rtl/dac_out_pkg.sv
// Shared types and constants for the DAC output path.
package dac_out_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } dac_state_t;

    // Offset-binary zero: the DAC sits here whenever playback is stopped.
    localparam logic [11:0] MIDSCALE = 12'h800;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with synchronous reset and flush.
module sync_fifo #(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            push,
    input  logic                            pop,
    input  logic [DATA_W-1:0]               wr_data,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            full,
    output logic                            empty,
    output logic [$clog2(FIFO_DEPTH):0]     level
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0]  mem_q [FIFO_DEPTH];
    logic               do_push;
    logic               do_pop;

    // Pointers carry one extra wrap bit so their difference is the occupancy.
    assign level   = wr_ptr_q - rd_ptr_q;
    assign full    = (level == (AW+1)'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;

    // Next pointer values; flush empties the buffer without touching storage.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage; contents are don't-care until written.
    always_ff @(posedge sys_clk) begin
        if (do_push && !reset) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/dac_data_out.sv
// Streams buffered samples to a parallel DAC bus at a programmable rate.
module dac_data_out
    import dac_out_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int PRIME_LVL  = 8,
    parameter int DIV_W      = 16
) (
    input  logic                            sys_clk,
    input  logic                            reset,
    input  logic                            enable,
    input  logic [DIV_W-1:0]                rate_div,
    input  logic [DATA_W-1:0]               s_data,
    input  logic                            s_valid,
    output logic                            s_ready,
    output logic [DATA_W-1:0]               dac_data,
    output logic                            dac_wr,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
    output logic                            running,
    output logic [15:0]                     underflow_cnt
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [LVL_W-1:0]  PRIME_THRESH = LVL_W'(PRIME_LVL);
    localparam logic [DATA_W-1:0] MID_WORD =
        (DATA_W == 12) ? DATA_W'(MIDSCALE) : {1'b1, {(DATA_W-1){1'b0}}};

    dac_state_t         state_q, state_d;
    logic [DIV_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  dac_data_q, dac_data_d;
    logic               tick_q, tick_d;
    logic               dac_wr_q, dac_wr_d;
    logic               running_q, running_d;
    logic [15:0]        ufl_q, ufl_d;

    logic               tick;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic [LVL_W-1:0]   fifo_level_w;

    assign s_ready   = enable & ~fifo_full;
    assign fifo_push = s_valid & s_ready;
    assign tick      = enable & (state_q == RUN) & (cnt_q == '0);
    assign fifo_pop  = tick & ~fifo_empty;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .reset   (reset),
        .flush   (~enable),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wr_data (s_data),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level_w)
    );

    // Sequencing, rate counter, output word, strobe pipeline and underflow count.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dac_data_d = dac_data_q;
        tick_d     = 1'b0;
        dac_wr_d   = 1'b0;
        ufl_d      = ufl_q;
        if (!enable) begin
            state_d    = IDLE;
            cnt_d      = '0;
            dac_data_d = MID_WORD;
        end else begin
            dac_wr_d = tick_q;
            case (state_q)
                IDLE:    state_d = PRIME;
                PRIME:   if (fifo_level_w >= PRIME_THRESH) state_d = RUN;
                RUN:     state_d = RUN;
                default: state_d = IDLE;
            endcase
            if (state_q == RUN) begin
                cnt_d = (cnt_q == '0) ? rate_div : cnt_q - DIV_W'(1);
            end else begin
                cnt_d = '0;
            end
            if (tick) begin
                tick_d = 1'b1;
                if (!fifo_empty) begin
                    dac_data_d = fifo_head;
                end else if (ufl_q != 16'hFFFF) begin
                    ufl_d = ufl_q + 16'd1;
                end
            end
        end
        running_d = (state_d == RUN);
    end

    // Control and output registers.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dac_data_q <= MID_WORD;
            tick_q     <= 1'b0;
            dac_wr_q   <= 1'b0;
            running_q  <= 1'b0;
            ufl_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dac_data_q <= dac_data_d;
            tick_q     <= tick_d;
            dac_wr_q   <= dac_wr_d;
            running_q  <= running_d;
            ufl_q      <= ufl_d;
        end
    end

    assign dac_data      = dac_data_q;
    assign dac_wr        = dac_wr_q;
    assign running       = running_q;
    assign underflow_cnt = ufl_q;
    assign fifo_level    = fifo_level_w;

endmodule
